// File: rtl/nx1_gram_arb.sv
// nx1_gram_arb: graphics RAM arbiter, display fetch vs CPU access.
// Optional simultaneous B/R/G write enabled by macro NX1_GRAM_WP_EN.
module nx1_gram_arb (
  input  logic        CLK,
  input  logic        I_RESET_N,
  input  logic        I_CPU_REQ,
  input  logic        I_CPU_WR,
  input  logic [13:0] I_CPU_A,
  input  logic [1:0]  I_CPU_PLANE,
  input  logic [7:0]  I_CPU_D,
  input  logic        I_GRAM_WP,
  output logic [7:0]  O_CPU_D,
  output logic        O_CPU_ACK,
  input  logic        I_DISP_REQ,
  input  logic [13:0] I_DISP_A,
  output logic [23:0] O_DISP_D,
  output logic        O_DISP_ACK,
  output logic [15:0] O_MEM_A,
  output logic        O_MEM_CE,
  output logic        O_MEM_WE,
  output logic [7:0]  O_MEM_D,
  input  logic [7:0]  I_MEM_Q
);

  localparam logic [3:0] IDLE = 4'd0;
  localparam logic [3:0] D0   = 4'd1;
  localparam logic [3:0] D1   = 4'd2;
  localparam logic [3:0] D2   = 4'd3;
  localparam logic [3:0] D3   = 4'd4;
  localparam logic [3:0] C0   = 4'd5;
  localparam logic [3:0] C1   = 4'd6;
  localparam logic [3:0] W0   = 4'd7;
  localparam logic [3:0] DONE = 4'd8;
`ifdef NX1_GRAM_WP_EN
  localparam logic [3:0] W1   = 4'd9;
  localparam logic [3:0] W2   = 4'd10;
`endif

  logic [3:0]  state;
  logic        last_disp;
  logic [13:0] off;
  logic [1:0]  plane;
  logic [7:0]  cap_b;
  logic [7:0]  cap_r;
  logic        grant_disp;
  logic [1:0]  wr_plane;

`ifdef NX1_GRAM_WP_EN
  logic        wp;
  assign wr_plane = I_GRAM_WP ? 2'd1 : I_CPU_PLANE;
`else
  logic        unused_wp;
  assign unused_wp = I_GRAM_WP;
  assign wr_plane  = I_CPU_PLANE;
`endif

  // display wins a tie unless it won the previous grant
  assign grant_disp = I_DISP_REQ &&
                      (!I_CPU_REQ || !last_disp);

  // access sequencer; every output is registered here
  always_ff @(posedge CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      state      <= IDLE;
      last_disp  <= 1'b0;
      off        <= '0;
      plane      <= '0;
      cap_b      <= '0;
      cap_r      <= '0;
`ifdef NX1_GRAM_WP_EN
      wp         <= 1'b0;
`endif
      O_CPU_D    <= '0;
      O_CPU_ACK  <= 1'b0;
      O_DISP_D   <= '0;
      O_DISP_ACK <= 1'b0;
      O_MEM_A    <= '0;
      O_MEM_CE   <= 1'b0;
      O_MEM_WE   <= 1'b0;
      O_MEM_D    <= '0;
    end else begin
      O_CPU_ACK  <= 1'b0;
      O_DISP_ACK <= 1'b0;
      O_MEM_CE   <= 1'b0;
      O_MEM_WE   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_disp) begin
            state     <= D0;
            last_disp <= 1'b1;
            off       <= I_DISP_A;
            O_MEM_A   <= {2'd1, I_DISP_A};
            O_MEM_CE  <= 1'b1;
          end else if (I_CPU_REQ) begin
            last_disp <= 1'b0;
            off       <= I_CPU_A;
            plane     <= I_CPU_PLANE;
            if (I_CPU_WR) begin
              state    <= W0;
`ifdef NX1_GRAM_WP_EN
              wp       <= I_GRAM_WP;
`endif
              O_MEM_A  <= {wr_plane, I_CPU_A};
              O_MEM_D  <= I_CPU_D;
              O_MEM_CE <= (wr_plane != 2'd0);
              O_MEM_WE <= (wr_plane != 2'd0);
            end else begin
              state    <= C0;
              O_MEM_A  <= {I_CPU_PLANE, I_CPU_A};
              O_MEM_CE <= (I_CPU_PLANE != 2'd0);
            end
          end
        end
        D0: begin
          state    <= D1;
          O_MEM_A  <= {2'd2, off};
          O_MEM_CE <= 1'b1;
        end
        D1: begin
          state    <= D2;
          cap_b    <= I_MEM_Q;
          O_MEM_A  <= {2'd3, off};
          O_MEM_CE <= 1'b1;
        end
        D2: begin
          state <= D3;
          cap_r <= I_MEM_Q;
        end
        D3: begin
          state      <= DONE;
          O_DISP_D   <= {I_MEM_Q, cap_r, cap_b};
          O_DISP_ACK <= 1'b1;
        end
        C0: begin
          state <= C1;
        end
        C1: begin
          state     <= DONE;
          O_CPU_D   <= (plane == 2'd0) ? 8'hFF
                                       : I_MEM_Q;
          O_CPU_ACK <= 1'b1;
        end
        W0: begin
`ifdef NX1_GRAM_WP_EN
          if (wp) begin
            state    <= W1;
            O_MEM_A  <= {2'd2, off};
            O_MEM_CE <= 1'b1;
            O_MEM_WE <= 1'b1;
          end else begin
            state     <= DONE;
            O_CPU_ACK <= 1'b1;
          end
`else
          state     <= DONE;
          O_CPU_ACK <= 1'b1;
`endif
        end
`ifdef NX1_GRAM_WP_EN
        W1: begin
          state    <= W2;
          O_MEM_A  <= {2'd3, off};
          O_MEM_CE <= 1'b1;
          O_MEM_WE <= 1'b1;
        end
        W2: begin
          state     <= DONE;
          O_CPU_ACK <= 1'b1;
        end
`endif
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nx1_gram_arb.sv
// tb_nx1_gram_arb: random + directed bench for nx1_gram_arb.
// Reference model predicts access lists, latencies and data.
module tb_nx1_gram_arb;

`ifdef NX1_GRAM_WP_EN
  localparam bit WP_ON = 1'b1;
`else
  localparam bit WP_ON = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        I_RESET_N = 1'b0;
  logic        I_CPU_REQ = 1'b0;
  logic        I_CPU_WR = 1'b0;
  logic [13:0] I_CPU_A = '0;
  logic [1:0]  I_CPU_PLANE = '0;
  logic [7:0]  I_CPU_D = '0;
  logic        I_GRAM_WP = 1'b0;
  logic [7:0]  O_CPU_D;
  logic        O_CPU_ACK;
  logic        I_DISP_REQ = 1'b0;
  logic [13:0] I_DISP_A = '0;
  logic [23:0] O_DISP_D;
  logic        O_DISP_ACK;
  logic [15:0] O_MEM_A;
  logic        O_MEM_CE;
  logic        O_MEM_WE;
  logic [7:0]  O_MEM_D;
  logic [7:0]  I_MEM_Q = '0;

  always #5 CLK = ~CLK;

  nx1_gram_arb dut (
    .CLK        (CLK),
    .I_RESET_N  (I_RESET_N),
    .I_CPU_REQ  (I_CPU_REQ),
    .I_CPU_WR   (I_CPU_WR),
    .I_CPU_A    (I_CPU_A),
    .I_CPU_PLANE(I_CPU_PLANE),
    .I_CPU_D    (I_CPU_D),
    .I_GRAM_WP  (I_GRAM_WP),
    .O_CPU_D    (O_CPU_D),
    .O_CPU_ACK  (O_CPU_ACK),
    .I_DISP_REQ (I_DISP_REQ),
    .I_DISP_A   (I_DISP_A),
    .O_DISP_D   (O_DISP_D),
    .O_DISP_ACK (O_DISP_ACK),
    .O_MEM_A    (O_MEM_A),
    .O_MEM_CE   (O_MEM_CE),
    .O_MEM_WE   (O_MEM_WE),
    .O_MEM_D    (O_MEM_D),
    .I_MEM_Q    (I_MEM_Q)
  );

  logic [7:0] ram     [65536];
  logic [7:0] mem_ref [65536];

  int         errs = 0;
  int         checks = 0;
  bit         last_m = 1'b0;
  logic [23:0] disp_m = '0;

  // synchronous RAM: data valid the cycle after a read strobe
  always @(posedge CLK) begin
    if (O_MEM_CE && O_MEM_WE) ram[O_MEM_A] <= O_MEM_D;
    if (O_MEM_CE && !O_MEM_WE) I_MEM_Q <= ram[O_MEM_A];
    else I_MEM_Q <= 8'($urandom);
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ent(
    input int c, input bit we,
    input logic [15:0] a, input logic [7:0] d);
    return {16'(c), 7'b0, we, a, we ? d : 8'h00};
  endfunction

  function automatic logic [59:0] outs();
    return {O_CPU_ACK, O_DISP_ACK, O_MEM_CE,
            O_MEM_WE, O_MEM_A, O_MEM_D,
            O_CPU_D, O_DISP_D};
  endfunction

  task automatic run_pair(
    input bit dr, input logic [13:0] da,
    input bit cr, input bit cw,
    input logic [1:0] cp, input logic [13:0] ca,
    input logic [7:0] cd, input bit wp);
    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    bit   dfirst;
    bit   wpe;
    int   st;
    int   lat_c;
    int   exp_ad;
    int   exp_ac;
    int   ack_d;
    int   ack_c;
    int   cyc;
    logic [7:0]  exp_cd;
    logic [23:0] exp_dd;
    wpe    = cw && wp && WP_ON;
    lat_c  = !cw ? 3 : (wpe ? 4 : 2);
    dfirst = dr && (!cr || !last_m);
    st     = 1;
    exp_ad = -1;
    exp_ac = -1;
    exp_cd = '0;
    exp_dd = disp_m;
    for (int k = 0; k < 2; k++) begin
      bit is_d;
      is_d = (k == 0) ? dfirst : !dfirst;
      if (is_d ? !dr : !cr) continue;
      if (is_d) begin
        for (int p = 1; p < 4; p++)
          exp_q.push_back(ent(st + p - 1, 1'b0,
                              {2'(p), da}, 8'h0));
        exp_dd = {mem_ref[{2'd3, da}],
                  mem_ref[{2'd2, da}],
                  mem_ref[{2'd1, da}]};
        exp_ad = st + 4;
        st     = st + 6;
        last_m = 1'b1;
      end else begin
        if (!cw) begin
          if (cp != 2'd0)
            exp_q.push_back(ent(st, 1'b0,
                                {cp, ca}, 8'h0));
          exp_cd = (cp != 2'd0) ?
                   mem_ref[{cp, ca}] : 8'hFF;
        end else if (wpe) begin
          for (int p = 1; p < 4; p++) begin
            exp_q.push_back(ent(st + p - 1, 1'b1,
                                {2'(p), ca}, cd));
            mem_ref[{2'(p), ca}] = cd;
          end
        end else if (cp != 2'd0) begin
          exp_q.push_back(ent(st, 1'b1,
                              {cp, ca}, cd));
          mem_ref[{cp, ca}] = cd;
        end
        exp_ac = st + lat_c - 1;
        st     = st + lat_c + 1;
        last_m = 1'b0;
      end
    end
    I_DISP_REQ  = dr;
    I_DISP_A    = da;
    I_CPU_REQ   = cr;
    I_CPU_WR    = cw;
    I_CPU_PLANE = cp;
    I_CPU_A     = ca;
    I_CPU_D     = cd;
    I_GRAM_WP   = wp;
    ack_d = -1;
    ack_c = -1;
    cyc   = 0;
    while (cyc < 40 &&
           ((dr && ack_d < 0) || (cr && ack_c < 0))) begin
      @(negedge CLK);
      cyc++;
      if (cyc == 1 && !(dr && cr)) begin
        I_DISP_A    = 14'($urandom);
        I_CPU_WR    = 1'($urandom);
        I_CPU_PLANE = 2'($urandom);
        I_CPU_A     = 14'($urandom);
        I_CPU_D     = 8'($urandom);
        I_GRAM_WP   = 1'($urandom);
      end
      if (O_MEM_CE)
        got_q.push_back(ent(cyc, O_MEM_WE,
                            O_MEM_A, O_MEM_D));
      if (O_DISP_ACK || O_CPU_ACK)
        chk("two_acks", {O_DISP_ACK, O_CPU_ACK},
            {1'b0, 1'b1} & {2{O_CPU_ACK}} |
            {1'b1, 1'b0} & {2{O_DISP_ACK}} &
            {2{~O_CPU_ACK}});
      if (O_DISP_ACK) begin
        ack_d = cyc;
        chk("disp_data", O_DISP_D, exp_dd);
        I_DISP_REQ = 1'b0;
      end
      if (O_CPU_ACK) begin
        ack_c = cyc;
        if (!cw) chk("cpu_data", O_CPU_D, exp_cd);
        I_CPU_REQ = 1'b0;
      end
    end
    I_DISP_REQ = 1'b0;
    I_CPU_REQ  = 1'b0;
    if (dr) chk("disp_ack_cyc", 64'(ack_d), 64'(exp_ad));
    if (cr) chk("cpu_ack_cyc", 64'(ack_c), 64'(exp_ac));
    chk("mem_acc_cnt", 64'(got_q.size()),
        64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() &&
                    i < got_q.size(); i++)
      chk("mem_acc", got_q[i], exp_q[i]);
    if (dr) disp_m = exp_dd;
    @(negedge CLK);
    chk("disp_hold", O_DISP_D, disp_m);
  endtask

  task automatic run_held(input logic [1:0] cp,
                          input logic [13:0] ca,
                          input logic [13:0] da);
    bit   want_d;
    int   n;
    int   cyc;
    logic [7:0]  exp_cd;
    logic [23:0] exp_dd;
    exp_cd = (cp != 2'd0) ? mem_ref[{cp, ca}] : 8'hFF;
    exp_dd = {mem_ref[{2'd3, da}], mem_ref[{2'd2, da}],
              mem_ref[{2'd1, da}]};
    want_d = !last_m;
    I_CPU_WR    = 1'b0;
    I_CPU_PLANE = cp;
    I_CPU_A     = ca;
    I_DISP_A    = da;
    I_CPU_REQ   = 1'b1;
    I_DISP_REQ  = 1'b1;
    n   = 0;
    cyc = 0;
    while (n < 4 && cyc < 60) begin
      @(negedge CLK);
      cyc++;
      if (O_DISP_ACK || O_CPU_ACK) begin
        chk("held_order", {O_DISP_ACK, O_CPU_ACK},
            want_d ? 2'b10 : 2'b01);
        if (O_DISP_ACK) chk("held_disp", O_DISP_D, exp_dd);
        if (O_CPU_ACK) chk("held_cpu", O_CPU_D, exp_cd);
        last_m = want_d;
        want_d = !want_d;
        n++;
      end
    end
    I_CPU_REQ  = 1'b0;
    I_DISP_REQ = 1'b0;
    chk("held_acks", 64'(n), 64'd4);
    disp_m = exp_dd;
    @(negedge CLK);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram[i]     = 8'($urandom);
      mem_ref[i] = ram[i];
    end
    ram[16'h4123] = 8'h11; mem_ref[16'h4123] = 8'h11;
    ram[16'h8123] = 8'h22; mem_ref[16'h8123] = 8'h22;
    ram[16'hC123] = 8'h33; mem_ref[16'hC123] = 8'h33;
    ram[16'h8005] = 8'hA5; mem_ref[16'h8005] = 8'hA5;
    repeat (3) @(negedge CLK);
    chk("reset_outs", outs(), '0);
    I_RESET_N = 1'b1;
    @(negedge CLK);
    run_pair(1, 14'h0123, 0, 0, 2'd0, 14'h0, 8'h0, 0);
    run_pair(0, 14'h0, 1, 0, 2'd2, 14'h0005, 8'h0, 0);
    run_pair(0, 14'h0, 1, 0, 2'd0, 14'h0005, 8'h0, 0);
    run_pair(0, 14'h0, 1, 1, 2'd1, 14'h0010, 8'h5A, 1);
    run_pair(0, 14'h0, 1, 1, 2'd3, 14'h0011, 8'h3C, 0);
    run_pair(0, 14'h0, 1, 1, 2'd0, 14'h0012, 8'h77, 0);
    run_held(2'd2, 14'h0005, 14'h0123);
    I_DISP_A   = 14'h0123;
    I_DISP_REQ = 1'b1;
    repeat (2) @(negedge CLK);
    I_RESET_N = 1'b0;
    #1;
    chk("rst_mid", outs(), '0);
    repeat (2) begin
      @(negedge CLK);
      chk("rst_hold", outs(), '0);
    end
    I_DISP_REQ = 1'b0;
    @(negedge CLK);
    I_RESET_N = 1'b1;
    last_m = 1'b0;
    disp_m = '0;
    @(negedge CLK);
    run_pair(1, 14'h0123, 1, 0, 2'd2, 14'h0005, 8'h0, 0);
    for (int i = 0; i < 150; i++) begin
      bit dr;
      bit cr;
      dr = 1'($urandom);
      cr = dr ? 1'($urandom) : 1'b1;
      run_pair(dr, 14'($urandom_range(0, 7)),
               cr, 1'($urandom), 2'($urandom),
               14'($urandom_range(0, 7)),
               8'($urandom), 1'($urandom));
    end
    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule

// File: doc/nx1_gram_arb.md
NX1_GRAM_ARB -- requirements
Module: nx1_gram_arb

Interface
REQ-001 SHALL have ports: CLK in 1, system clock, all logic on its rising edge.
REQ-002 SHALL have ports: I_RESET_N in 1, asynchronous active-low reset.
REQ-003 SHALL have ports: I_CPU_REQ in 1, CPU access request, level, held until O_CPU_ACK.
REQ-004 SHALL have ports: I_CPU_WR in 1, 1=write, 0=read; I_CPU_A in 14, plane offset; I_CPU_PLANE in 2, 1=B, 2=R, 3=G, 0=none; I_CPU_D in 8, write data.
REQ-005 SHALL have ports: I_GRAM_WP in 1, simultaneous-write mode from turbo mode latch 1FD0 bit 4.
REQ-006 SHALL have ports: O_CPU_D out 8, read data; O_CPU_ACK out 1, one-cycle completion pulse.
REQ-007 SHALL have ports: I_DISP_REQ in 1, display fetch request, level, held until O_DISP_ACK; I_DISP_A in 14, fetch offset.
REQ-008 SHALL have ports: O_DISP_D out 24, {G,R,B} bytes; O_DISP_ACK out 1, one-cycle completion pulse.
REQ-009 SHALL have ports: O_MEM_A out 16 = {plane[1:0], offset[13:0]}; O_MEM_CE out 1; O_MEM_WE out 1; O_MEM_D out 8; I_MEM_Q in 8, valid the cycle after CE with WE=0.

Function
REQ-010 SHALL use FSM states IDLE, D0, D1, D2, D3, C0, C1, W0, W1, W2, DONE; all outputs registered.
REQ-011 SHALL sample requests only in IDLE; never in DONE.
REQ-012 SHALL grant display when both request, unless the previous grant was display; then CPU wins (alternation, no starvation).
REQ-013 Display: IDLE(req seen, cycle 0) -> D0 read B -> D1 read R, capture B -> D2 read G, capture R -> D3 capture G -> DONE; O_DISP_ACK=1 and new O_DISP_D in cycle 5.
REQ-014 O_DISP_D SHALL hold its value until the next display completion.
REQ-015 CPU read: IDLE -> C0 (CE, plane address) -> C1 (capture I_MEM_Q) -> DONE; O_CPU_ACK in cycle 3.
REQ-016 CPU read with plane 0 SHALL issue no CE and return 8'hFF with the same timing.
REQ-017 CPU single write: IDLE -> W0 (CE, WE, O_MEM_D=I_CPU_D) -> DONE; O_CPU_ACK in cycle 2; plane 0 SHALL suppress CE/WE.
REQ-018 CPU write with I_GRAM_WP=1 (macro enabled): W0 plane 1, W1 plane 2, W2 plane 3, same data and offset -> DONE; O_CPU_ACK in cycle 4; I_CPU_PLANE ignored.
REQ-019 I_GRAM_WP and request fields SHALL be captured at grant; later changes do not affect the access in progress.
REQ-020 DONE SHALL return to IDLE unconditionally after one cycle.
REQ-021 O_MEM_CE/O_MEM_WE SHALL be 0 in IDLE, C1, D3, DONE.
REQ-022 At most one O_*_ACK SHALL be asserted per cycle.

Reset
REQ-023 Reset asserted at any time, including mid-access, SHALL force IDLE immediately. It SHALL clear O_CPU_ACK, O_DISP_ACK, O_MEM_CE, O_MEM_WE, O_MEM_A, O_MEM_D, O_CPU_D and O_DISP_D to 0. It SHALL set last-grant to CPU.
REQ-024 After reset release, the first simultaneous request SHALL go to display.

Configuration
REQ-025 Macro NX1_GRAM_WP_EN defined: REQ-018 simultaneous write is implemented and W1/W2 exist.
REQ-026 Macro NX1_GRAM_WP_EN undefined: I_GRAM_WP is ignored, all writes follow REQ-017, and W1/W2 are absent.

Verification
REQ-027 Display only: I_DISP_A=14'h0123, memory B=11, R=22, G=33 -> O_MEM_A 4123, 8123, C123 on cycles 1-3; O_DISP_ACK at cycle 5; O_DISP_D=24'h332211.
REQ-028 CPU read: plane 2, A=14'h0005, mem=8'hA5 -> O_CPU_D=A5 and ACK at cycle 3; plane 0 -> FF with no CE.
REQ-029 Macro on, I_GRAM_WP=1, write 8'h5A to A=14'h0010 -> WE at 4010, 8010, C010 on consecutive cycles; ACK at cycle 4.
REQ-030 Both requests held continuously -> grants alternate display, CPU, display, CPU; no two ACKs coincide.
REQ-031 Reset pulsed in D1 -> all outputs 0 at once; no ACK; after release a fresh display request completes normally.
